// File: rtl/zigzag_rle_serializer.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_rle_serializer
// Purpose  : Captures one zigzag-ordered 8x8 coefficient block and streams
//            DC / (run,value) / ZRL / EOB tokens toward the Huffman coder.
// Revision : 1.0
// ============================================================================
module zigzag_rle_serializer #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 64
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          block_valid,
    output logic                          block_ready,
    input  logic [DATA_WIDTH*DEPTH-1:0]   zigzag_pix_in,
    output logic                          rle_valid,
    input  logic                          rle_ready,
    output logic [3:0]                    rle_run,
    output logic [DATA_WIDTH-1:0]         rle_value,
    output logic                          rle_is_dc,
    output logic                          rle_zrl,
    output logic                          rle_eob
);

    localparam int                 c_IDX_W    = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EOB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_coef [DEPTH];
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    r_last_nz;
    logic [3:0]            r_run;

    logic [c_IDX_W-1:0]    w_last_nz;
    logic                  w_accept;
    logic                  w_slot_free;
    logic [DATA_WIDTH-1:0] w_cur;

    assign block_ready = (r_state == S_IDLE);
    assign w_accept    = block_valid && block_ready;
    assign w_slot_free = !rle_valid || rle_ready;
    assign w_cur       = r_coef[r_idx];

    // Highest nonzero AC index wins; 0 means the block has no AC energy.
    always_comb begin
        w_last_nz = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (zigzag_pix_in[k*DATA_WIDTH +: DATA_WIDTH] != '0) begin
                w_last_nz = c_IDX_W'(k);
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_coef
            always_ff @(posedge clock) begin
                if (w_accept) begin
                    r_coef[g] <= zigzag_pix_in[g*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_last_nz <= '0;
            r_run     <= '0;
            rle_valid <= 1'b0;
            rle_run   <= '0;
            rle_value <= '0;
            rle_is_dc <= 1'b0;
            rle_zrl   <= 1'b0;
            rle_eob   <= 1'b0;
        end else begin
            // A consumed token frees the slot unless a new one is loaded below.
            if (rle_valid && rle_ready) begin
                rle_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        rle_valid <= 1'b1;
                        rle_run   <= 4'd0;
                        rle_value <= zigzag_pix_in[DATA_WIDTH-1:0];
                        rle_is_dc <= 1'b1;
                        rle_zrl   <= 1'b0;
                        rle_eob   <= 1'b0;
                        r_last_nz <= w_last_nz;
                        r_idx     <= c_IDX_W'(1);
                        r_run     <= 4'd0;
                        r_state   <= (w_last_nz == '0) ? S_EOB : S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (w_slot_free) begin
                        if (w_cur != '0) begin
                            rle_valid <= 1'b1;
                            rle_run   <= r_run;
                            rle_value <= w_cur;
                            rle_is_dc <= 1'b0;
                            rle_zrl   <= 1'b0;
                            rle_eob   <= 1'b0;
                            r_run     <= 4'd0;
                        end else if (r_run == 4'd15 && r_idx < r_last_nz) begin
                            rle_valid <= 1'b1;
                            rle_run   <= 4'd15;
                            rle_value <= '0;
                            rle_is_dc <= 1'b0;
                            rle_zrl   <= 1'b1;
                            rle_eob   <= 1'b0;
                            r_run     <= 4'd0;
                        end else begin
                            r_run <= r_run + 4'd1;
                        end

                        // A block ending on the last coefficient needs no EOB.
                        if (r_idx == r_last_nz) begin
                            r_state <= (r_last_nz == c_LAST_IDX) ? S_DONE : S_EOB;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end

                S_EOB: begin
                    if (w_slot_free) begin
                        rle_valid <= 1'b1;
                        rle_run   <= 4'd0;
                        rle_value <= '0;
                        rle_is_dc <= 1'b0;
                        rle_zrl   <= 1'b0;
                        rle_eob   <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (w_slot_free) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_rle_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_rle_serializer
// Purpose  : Directed and random token-stream checks against a gap-based model.
// Revision : 1.0
// ============================================================================
module tb_zigzag_rle_serializer;

    localparam int DW = 10;
    localparam int N  = 64;

    typedef struct packed {
        logic [3:0]    run;
        logic [DW-1:0] value;
        logic          dc;
        logic          zrl;
        logic          eob;
    } tok_t;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            block_valid = 1'b0;
    logic            block_ready;
    logic [DW*N-1:0] zigzag_pix_in = '0;
    logic            rle_valid;
    logic            rle_ready = 1'b1;
    logic [3:0]      rle_run;
    logic [DW-1:0]   rle_value;
    logic            rle_is_dc;
    logic            rle_zrl;
    logic            rle_eob;

    zigzag_rle_serializer #(.DATA_WIDTH(DW), .DEPTH(N)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .zigzag_pix_in(zigzag_pix_in),
        .rle_valid    (rle_valid),
        .rle_ready    (rle_ready),
        .rle_run      (rle_run),
        .rle_value    (rle_value),
        .rle_is_dc    (rle_is_dc),
        .rle_zrl      (rle_zrl),
        .rle_eob      (rle_eob)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] blk [N];
    tok_t exp_tok [$];
    int   exp_idx [$];
    tok_t got     [$];
    int   got_cyc [$];
    int   acc     [$];
    int   T;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each nonzero AC preceded by gap/16 ZRLs and a (gap%16) run.
    task automatic build_expected();
        tok_t t;
        int   prev, gap;
        exp_tok.delete();
        exp_idx.delete();
        t = '0; t.dc = 1'b1; t.value = blk[0];
        exp_tok.push_back(t); exp_idx.push_back(0);
        prev = 0;
        for (int k = 1; k < N; k++) begin
            if (blk[k] != '0) begin
                gap = k - prev - 1;
                for (int j = 1; j <= gap / 16; j++) begin
                    t = '0; t.zrl = 1'b1; t.run = 4'd15;
                    exp_tok.push_back(t); exp_idx.push_back(prev + 16 * j);
                end
                t = '0; t.run = 4'(gap % 16); t.value = blk[k];
                exp_tok.push_back(t); exp_idx.push_back(k);
                prev = k;
            end
        end
        if (prev != N - 1) begin
            t = '0; t.eob = 1'b1;
            exp_tok.push_back(t); exp_idx.push_back(prev + 1);
        end
    endtask

    // Handshake/acceptance recorder plus hold-stability and flag checks.
    bit   hold_pend = 1'b0;
    tok_t held;
    always @(negedge clock) begin
        tok_t cur;
        cur = {rle_run, rle_value, rle_is_dc, rle_zrl, rle_eob};
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (block_valid && block_ready) acc.push_back(cyc);
            if (hold_pend) check("hold", {15'd0, rle_valid, cur}, {15'd0, 1'b1, held});
            if (rle_valid) check("flags_onehot", 32'($countones({rle_is_dc, rle_zrl, rle_eob}) <= 1), 32'd1);
            if (rle_valid && rle_ready) begin
                got.push_back(cur);
                got_cyc.push_back(cyc);
            end
            hold_pend = rle_valid && !rle_ready;
            held      = cur;
        end
    end

    task automatic clear_blk();
        for (int k = 0; k < N; k++) blk[k] = '0;
    endtask

    task automatic start_block(input bit keep);
        for (int k = 0; k < N; k++) zigzag_pix_in[k*DW +: DW] = blk[k];
        build_expected();
        got.delete(); got_cyc.delete(); acc.delete();
        @(posedge clock); #1 block_valid = 1'b1;
        for (int w = 0; w < 50 && acc.size() == 0; w++) begin
            @(negedge clock); #1;
        end
        check("accept", 32'(acc.size() != 0), 32'd1);
        T = (acc.size() != 0) ? acc[0] : cyc;
        if (!keep) begin
            @(posedge clock); #1 block_valid = 1'b0;
        end
    endtask

    task automatic finish_block(input int shift, input bit chk_cyc, input bit rnd);
        bit done = 1'b0;
        for (int w = 0; w < 3000 && !done; w++) begin
            @(posedge clock); #1;
            if (rnd) rle_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock); #1;
            if (got.size() >= exp_tok.size() && block_ready) done = 1'b1;
        end
        rle_ready = 1'b1;
        check("done", 32'(done), 32'd1);
        check("count", 32'(got.size()), 32'(exp_tok.size()));
        for (int i = 0; i < exp_tok.size() && i < got.size(); i++) begin
            check($sformatf("tok%0d", i), 32'(got[i]), 32'(exp_tok[i]));
            if (chk_cyc)
                check($sformatf("cyc%0d", i), 32'(got_cyc[i]), 32'(T + 1 + exp_idx[i] + ((i >= 1) ? shift : 0)));
        end
        if (done && got.size() != 0) check("ready_back", 32'(cyc), 32'(got_cyc[got.size()-1] + 1));
    endtask

    task automatic set_scn2();
        clear_blk();
        blk[0] = 10'h3FD; blk[1] = 10'd2; blk[5] = 10'h3FF;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_outputs", {25'd0, rle_valid, rle_run, rle_is_dc, rle_zrl, rle_eob}, 32'd0);
        check("rst_value", 32'(rle_value), 32'd0);
        check("rst_block_ready", 32'(block_ready), 32'd1);
        @(posedge clock); #1 reset_n = 1'b1;

        // DC only
        clear_blk(); blk[0] = 10'd5;
        start_block(0); finish_block(0, 1, 0);

        // DC plus two AC values
        set_scn2();
        start_block(0); finish_block(0, 1, 0);

        // Only the last coefficient nonzero: three ZRLs, no EOB
        clear_blk(); blk[63] = 10'd1;
        start_block(0); finish_block(0, 1, 0);

        // One ZRL, no trailing ZRL after idx 20
        clear_blk(); blk[20] = 10'd7;
        start_block(0); finish_block(0, 1, 0);

        // Backpressure on (0,2) while block_valid stays asserted
        set_scn2();
        start_block(1);
        @(posedge clock); #1;
        @(posedge clock); #1 rle_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 rle_ready = 1'b1;
        finish_block(5, 1, 0);
        check("next_accept_seen", 32'(acc.size() >= 2), 32'd1);
        if (acc.size() >= 2 && got.size() != 0)
            check("next_accept_cyc", 32'(acc[1]), 32'(got_cyc[got.size()-1] + 1));
        if (acc.size() >= 2) begin
            got.delete(); got_cyc.delete();
            T = acc[1];
            @(posedge clock); #1 block_valid = 1'b0;
            finish_block(0, 1, 0);
        end else begin
            block_valid = 1'b0;
        end

        // Asynchronous reset mid-block, then a clean block
        clear_blk(); blk[63] = 10'd9; blk[30] = 10'h200;
        start_block(0);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_outputs", {25'd0, rle_valid, rle_run, rle_is_dc, rle_zrl, rle_eob}, 32'd0);
        check("midrst_value", 32'(rle_value), 32'd0);
        check("midrst_block_ready", 32'(block_ready), 32'd1);
        @(posedge clock); #1 reset_n = 1'b1;
        set_scn2();
        start_block(0); finish_block(0, 1, 0);

        // Random blocks with random backpressure
        for (int b = 0; b < 10; b++) begin
            int dens;
            dens = $urandom_range(0, 40);
            for (int k = 0; k < N; k++)
                blk[k] = ($urandom_range(0, 99) < dens) ? 10'($urandom_range(1, 1023)) : 10'd0;
            blk[0] = 10'($urandom_range(0, 1023));
            if (b % 3 == 0) blk[63] = 10'($urandom_range(1, 1023));
            start_block(0);
            finish_block(0, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
